// File: rtl/ex_mem_pipe_stage_if.sv
// Bundle of ID/EX-side, EX/MEM-side and fetch-redirect signals for ex_mem_pipe_stage.
//   master : upstream/downstream environment that drives instructions, out_ready
//   slave  : the execute stage itself
// Ports summary (slave view):
//   in_valid/in_ready, alu_ctrl, rd1, rd2, pc, imm, branch, br_funct3, rd_addr,
//   memwrite_in/memread_in/memtoreg_in/regwrite_in               -> inputs (except in_ready)
//   out_valid/out_ready, out_alu, out_rd2, out_pc4, out_zero, out_rd_addr,
//   out_memwrite/out_memread/out_memtoreg/out_regwrite,
//   redirect_valid, redirect_pc                                  -> outputs (except out_ready)
interface ex_mem_pipe_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_ctrl;
  logic [XLEN-1:0]       rd1;
  logic [XLEN-1:0]       rd2;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       imm;
  logic                  branch;
  logic [2:0]            br_funct3;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  memwrite_in;
  logic                  memread_in;
  logic                  memtoreg_in;
  logic                  regwrite_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_alu;
  logic [XLEN-1:0]       out_rd2;
  logic [XLEN-1:0]       out_pc4;
  logic                  out_zero;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic                  out_memwrite;
  logic                  out_memread;
  logic                  out_memtoreg;
  logic                  out_regwrite;

  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;

  modport master (
    output in_valid, alu_ctrl, rd1, rd2, pc, imm, branch, br_funct3, rd_addr,
           memwrite_in, memread_in, memtoreg_in, regwrite_in, out_ready,
    input  in_ready, out_valid, out_alu, out_rd2, out_pc4, out_zero, out_rd_addr,
           out_memwrite, out_memread, out_memtoreg, out_regwrite,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, alu_ctrl, rd1, rd2, pc, imm, branch, br_funct3, rd_addr,
           memwrite_in, memread_in, memtoreg_in, regwrite_in, out_ready,
    output in_ready, out_valid, out_alu, out_rd2, out_pc4, out_zero, out_rd_addr,
           out_memwrite, out_memread, out_memtoreg, out_regwrite,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// Execute stage fused with the EX/MEM pipeline register.
// Computes the ALU result, resolves conditional branches (redirect pulse on the
// accept edge) and optionally runs a one-bit-per-cycle shift-add multiplier.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (priority over flush)
//   flush : kills the held output and any multiply in progress; blocks accept
//   bus   : ex_mem_pipe_stage_if.slave (instruction in, EX/MEM register out, redirect)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a new instruction when the output slot is free
// MUL_BUSY | multiply in progress, one shift-add step per cycle
module ex_mem_pipe_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  ex_mem_pipe_stage_if.slave      bus
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]       acc_q, acc_d;
  logic [XLEN-1:0]       mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic [XLEN-1:0]       pend_rd2_q, pend_rd2_d;
  logic [XLEN-1:0]       pend_pc4_q, pend_pc4_d;
  logic [REG_ADDR_W-1:0] pend_rd_addr_q, pend_rd_addr_d;
  logic [3:0]            pend_ctrl_q, pend_ctrl_d;

  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_alu_q, out_alu_d;
  logic [XLEN-1:0]       out_rd2_q, out_rd2_d;
  logic [XLEN-1:0]       out_pc4_q, out_pc4_d;
  logic                  out_zero_q, out_zero_d;
  logic [REG_ADDR_W-1:0] out_rd_addr_q, out_rd_addr_d;
  logic [3:0]            out_ctrl_q, out_ctrl_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;

  logic [SHW-1:0]        shamt;
  logic [XLEN-1:0]       alu_res;
  logic                  br_taken;
  logic                  eq, lt_s, lt_u;
  logic [XLEN-1:0]       br_target;
  logic [XLEN-1:0]       pc4;
  logic [3:0]            in_ctrl;
  logic                  is_mul;
  logic                  in_ready;
  logic                  accept;
  logic [XLEN-1:0]       acc_step;

  always_comb begin
    shamt   = bus.rd2[SHW-1:0];
    alu_res = '0;
    case (bus.alu_ctrl)
      4'b0000: alu_res = bus.rd1 & bus.rd2;
      4'b0001: alu_res = bus.rd1 | bus.rd2;
      4'b1001: alu_res = bus.rd1 ^ bus.rd2;
      4'b0010: alu_res = bus.rd1 + bus.rd2;
      4'b0110: alu_res = bus.rd1 - bus.rd2;
      4'b0011: alu_res = bus.rd1 << shamt;
      4'b0100: alu_res = bus.rd1 >> shamt;
      4'b0101: alu_res = $signed(bus.rd1) >>> shamt;
      4'b0111: alu_res = {{(XLEN-1){1'b0}}, lt_s};
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      // MUL is produced by the multiplier when present; without it the code yields 0
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    eq   = (bus.rd1 == bus.rd2);
    lt_s = ($signed(bus.rd1) < $signed(bus.rd2));
    lt_u = (bus.rd1 < bus.rd2);
    br_taken = 1'b0;
    case (bus.br_funct3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt_s;
      3'b101:  br_taken = !lt_s;
      3'b110:  br_taken = lt_u;
      3'b111:  br_taken = !lt_u;
      default: br_taken = 1'b0;
    endcase
  end

  assign br_target = bus.pc + (bus.imm << 1);
  assign pc4       = bus.pc + XLEN'(4);
  assign in_ctrl   = {bus.memwrite_in, bus.memread_in, bus.memtoreg_in, bus.regwrite_in};
  assign is_mul    = MUL_EN && (bus.alu_ctrl == 4'b1010);
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
  assign accept    = bus.in_valid && in_ready;
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    acc_d            = acc_q;
    mcand_d          = mcand_q;
    mplier_d         = mplier_q;
    pend_rd2_d       = pend_rd2_q;
    pend_pc4_d       = pend_pc4_q;
    pend_rd_addr_d   = pend_rd_addr_q;
    pend_ctrl_d      = pend_ctrl_q;
    out_valid_d      = out_valid_q;
    out_alu_d        = out_alu_q;
    out_rd2_d        = out_rd2_q;
    out_pc4_d        = out_pc4_q;
    out_zero_d       = out_zero_q;
    out_rd_addr_d    = out_rd_addr_q;
    out_ctrl_d       = out_ctrl_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      cnt_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.branch && br_taken) begin
              redirect_valid_d = 1'b1;
              redirect_pc_d    = br_target;
            end
            if (is_mul) begin
              acc_d          = '0;
              mcand_d        = bus.rd1;
              mplier_d       = bus.rd2;
              cnt_d          = '0;
              pend_rd2_d     = bus.rd2;
              pend_pc4_d     = pc4;
              pend_rd_addr_d = bus.rd_addr;
              pend_ctrl_d    = in_ctrl;
              state_d        = MUL_BUSY;
            end else begin
              out_valid_d   = 1'b1;
              out_alu_d     = alu_res;
              out_rd2_d     = bus.rd2;
              out_pc4_d     = pc4;
              out_zero_d    = (alu_res == '0);
              out_rd_addr_d = bus.rd_addr;
              out_ctrl_d    = in_ctrl;
            end
          end
        end
        MUL_BUSY: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          // wraps back to 0 on the final step since XLEN is a power of two
          cnt_d    = cnt_q + SHW'(1);
          if (cnt_q == SHW'(XLEN-1)) begin
            out_valid_d   = 1'b1;
            out_alu_d     = acc_step;
            out_rd2_d     = pend_rd2_q;
            out_pc4_d     = pend_pc4_q;
            out_zero_d    = (acc_step == '0);
            out_rd_addr_d = pend_rd_addr_q;
            out_ctrl_d    = pend_ctrl_q;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      acc_q            <= '0;
      mcand_q          <= '0;
      mplier_q         <= '0;
      pend_rd2_q       <= '0;
      pend_pc4_q       <= '0;
      pend_rd_addr_q   <= '0;
      pend_ctrl_q      <= '0;
      out_valid_q      <= 1'b0;
      out_alu_q        <= '0;
      out_rd2_q        <= '0;
      out_pc4_q        <= '0;
      out_zero_q       <= 1'b0;
      out_rd_addr_q    <= '0;
      out_ctrl_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      mcand_q          <= mcand_d;
      mplier_q         <= mplier_d;
      pend_rd2_q       <= pend_rd2_d;
      pend_pc4_q       <= pend_pc4_d;
      pend_rd_addr_q   <= pend_rd_addr_d;
      pend_ctrl_q      <= pend_ctrl_d;
      out_valid_q      <= out_valid_d;
      out_alu_q        <= out_alu_d;
      out_rd2_q        <= out_rd2_d;
      out_pc4_q        <= out_pc4_d;
      out_zero_q       <= out_zero_d;
      out_rd_addr_q    <= out_rd_addr_d;
      out_ctrl_q       <= out_ctrl_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_alu        = out_alu_q;
  assign bus.out_rd2        = out_rd2_q;
  assign bus.out_pc4        = out_pc4_q;
  assign bus.out_zero       = out_zero_q;
  assign bus.out_rd_addr    = out_rd_addr_q;
  assign bus.out_memwrite   = out_ctrl_q[3];
  assign bus.out_memread    = out_ctrl_q[2];
  assign bus.out_memtoreg   = out_ctrl_q[1];
  assign bus.out_regwrite   = out_ctrl_q[0];
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
module tb_ex_mem_pipe_stage;
  localparam int XLEN = 64;
  localparam logic [3:0] OP_AND = 4'b0000, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_SLL = 4'b0011, OP_SRA = 4'b0101, OP_MUL = 4'b1010;
  localparam logic [63:0] SIGN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage_if #(.XLEN(XLEN), .REG_ADDR_W(5)) bus ();
  ex_mem_pipe_stage_if #(.XLEN(XLEN), .REG_ADDR_W(5)) bus_nm ();

  ex_mem_pipe_stage #(.XLEN(XLEN), .REG_ADDR_W(5), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus));
  ex_mem_pipe_stage #(.XLEN(XLEN), .REG_ADDR_W(5), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_nm));

  // Reference: ALU result straight from the operation definitions
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int s;
    logic [63:0] fill;
    s = int'(b[5:0]);
    fill = a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> s) : 64'd0;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd9:  return a ^ b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd3:  return a << s;
      4'd4:  return a >> s;
      4'd5:  return (a >> s) | fill;
      4'd7:  return ((a ^ SIGN) < (b ^ SIGN)) ? 64'd1 : 64'd0;
      4'd8:  return (a < b) ? 64'd1 : 64'd0;
      4'd10: return a * b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic slt;
    slt = (a ^ SIGN) < (b ^ SIGN);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return slt;
      3'd5: return !slt;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] p, input logic [63:0] im, input logic br, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [3:0] cb);
    bus.in_valid = v; bus.alu_ctrl = op; bus.rd1 = a; bus.rd2 = b; bus.pc = p; bus.imm = im;
    bus.branch = br; bus.br_funct3 = f3; bus.rd_addr = rd;
    {bus.memwrite_in, bus.memread_in, bus.memtoreg_in, bus.regwrite_in} = cb;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 3'd0, 5'd0, 4'd0);
  endtask

  task automatic drain();
    idle();
    bus.out_ready = 1'b1;
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_alu !== 64'd0) begin n_err++; $display("FAIL reset_out_alu: got %h want 0", bus.out_alu); end
    n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 64'd0) begin n_err++;
      $display("FAIL reset_redirect: got %b/%h want 0/0", bus.redirect_valid, bus.redirect_pc); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    drive(1'b1, OP_ADD, 64'd5, 64'd7, 64'h100, 64'd0, 1'b0, 3'd0, 5'd3, 4'b0001);
    tick();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_alu !== 64'd12) begin n_err++; $display("FAIL add_alu: got %h want c", bus.out_alu); end
    n_cmp++; if (bus.out_pc4 !== 64'h104) begin n_err++; $display("FAIL add_pc4: got %h want 104", bus.out_pc4); end
    n_cmp++; if (bus.out_zero !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_err++;
      $display("FAIL add_zero_redir: got %b/%b want 0/0", bus.out_zero, bus.redirect_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL add_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_branch();
    drive(1'b1, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h200, 64'd8, 1'b1, 3'b100, 5'd0, 4'd0);
    tick();
    idle();
    n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h210) begin n_err++;
      $display("FAIL blt_redirect: got %b/%h want 1/210", bus.redirect_valid, bus.redirect_pc); end
    tick();
    n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL blt_pulse: got %b want 0", bus.redirect_valid); end
    drive(1'b1, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h200, 64'd8, 1'b1, 3'b110, 5'd0, 4'd0);
    tick();
    idle();
    n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL bltu_redirect: got %b want 0", bus.redirect_valid); end
    tick();
  endtask

  task automatic test_shifts();
    drive(1'b1, OP_SRA, SIGN, 64'd4, 64'h40, 64'd0, 1'b0, 3'd0, 5'd1, 4'd0);
    tick();
    drive(1'b1, OP_SLL, 64'd3, 64'd65, 64'h44, 64'd0, 1'b0, 3'd0, 5'd1, 4'd0);
    n_cmp++; if (bus.out_alu !== 64'hF800_0000_0000_0000) begin n_err++;
      $display("FAIL sra: got %h want f800000000000000", bus.out_alu); end
    tick();
    idle();
    n_cmp++; if (bus.out_alu !== 64'd6) begin n_err++; $display("FAIL sll65: got %h want 6", bus.out_alu); end
    tick();
  endtask

  // Back-to-back random non-MUL stream, one instruction per cycle
  task automatic test_back_to_back();
    logic [3:0] op; logic [63:0] a, b, p, im, e; logic br, tk; logic [2:0] f3; logic [4:0] rd; logic [3:0] cb;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == OP_MUL) op = OP_ADD;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 70));
      p = {$urandom, $urandom}; im = {$urandom, $urandom};
      br = 1'($urandom); f3 = 3'($urandom); rd = 5'($urandom); cb = 4'($urandom);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      drive(1'b1, op, a, b, p, im, br, f3, rd, cb);
      tick();
      e = ref_alu(op, a, b);
      tk = br && ref_taken(f3, a, b);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_alu !== e || bus.out_zero !== (e == 64'd0)) begin n_err++;
        $display("FAIL b2b_alu[%0d] op=%h: got %b/%h/%b want 1/%h/%b", i, op, bus.out_valid, bus.out_alu, bus.out_zero, e, e == 64'd0); end
      n_cmp++; if (bus.out_rd2 !== b || bus.out_pc4 !== p + 64'd4 || bus.out_rd_addr !== rd ||
                   {bus.out_memwrite, bus.out_memread, bus.out_memtoreg, bus.out_regwrite} !== cb) begin n_err++;
        $display("FAIL b2b_fields[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b", i, bus.out_rd2, bus.out_pc4, bus.out_rd_addr,
                 {bus.out_memwrite, bus.out_memread, bus.out_memtoreg, bus.out_regwrite}, b, p + 64'd4, rd, cb); end
      n_cmp++; if (bus.redirect_valid !== tk || (tk && bus.redirect_pc !== p + (im << 1))) begin n_err++;
        $display("FAIL b2b_redirect[%0d] f3=%0d: got %b/%h want %b/%h", i, f3, bus.redirect_valid, bus.redirect_pc, tk, p + (im << 1)); end
    end
    idle();
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_err++;
      $display("FAIL b2b_end: got %b/%b want 0/0", bus.out_valid, bus.redirect_valid); end
  endtask

  task automatic test_mul();
    logic [63:0] a, b;
    int lat;
    logic busy_ready;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 64'h1234 : {$urandom, $urandom};
      b = (i == 0) ? 64'h10 : {$urandom, $urandom};
      drive(1'b1, OP_MUL, a, b, 64'h500, 64'd0, 1'b0, 3'd0, 5'd9, 4'b0001);
      tick();
      idle();
      lat = 0;
      busy_ready = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
        if (bus.in_ready !== 1'b0) busy_ready = 1'b1;
        tick();
        lat++;
      end
      n_cmp++; if (lat != XLEN) begin n_err++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, XLEN); end
      n_cmp++; if (busy_ready !== 1'b0) begin n_err++; $display("FAIL mul_in_ready_busy[%0d]: got 1 want 0", i); end
      n_cmp++; if (bus.out_alu !== a * b || bus.out_pc4 !== 64'h504 || bus.out_rd_addr !== 5'd9) begin n_err++;
        $display("FAIL mul_result[%0d]: got %h/%h/%h want %h/504/9", i, bus.out_alu, bus.out_pc4, bus.out_rd_addr, a * b); end
      tick();
    end
  endtask

  task automatic test_mul_disabled();
    bus_nm.in_valid = 1'b1; bus_nm.alu_ctrl = OP_MUL; bus_nm.rd1 = 64'h1234; bus_nm.rd2 = 64'h10;
    tick();
    bus_nm.in_valid = 1'b0;
    n_cmp++; if (bus_nm.out_valid !== 1'b1 || bus_nm.out_alu !== 64'd0 || bus_nm.out_zero !== 1'b1) begin n_err++;
      $display("FAIL mul_disabled: got %b/%h/%b want 1/0/1", bus_nm.out_valid, bus_nm.out_alu, bus_nm.out_zero); end
    tick();
  endtask

  task automatic test_backpressure();
    logic stable;
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 64'd10, 64'd20, 64'h600, 64'd0, 1'b0, 3'd0, 5'd4, 4'd0);
    tick();
    drive(1'b1, OP_SUB, 64'd50, 64'd8, 64'h604, 64'd0, 1'b0, 3'd0, 5'd5, 4'd0);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    stable = 1'b1;
    repeat (3) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_alu !== 64'd30 || bus.out_rd_addr !== 5'd4) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b/%h want 1/1e", bus.out_valid, bus.out_alu); end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    tick();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_alu !== 64'd42 || bus.out_rd_addr !== 5'd5) begin n_err++;
      $display("FAIL bp_next: got %b/%h/%h want 1/2a/5", bus.out_valid, bus.out_alu, bus.out_rd_addr); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic rose;
    drive(1'b1, OP_MUL, 64'h1234, 64'h10, 64'h700, 64'd0, 1'b0, 3'd0, 5'd1, 4'd0);
    tick();
    idle();
    repeat (9) tick();
    flush = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL flush_mul_abort: got %b/%b want 0/1", bus.out_valid, bus.in_ready); end
    rose = 1'b0;
    repeat (70) begin tick(); if (bus.out_valid !== 1'b0) rose = 1'b1; end
    n_cmp++; if (rose !== 1'b0) begin n_err++; $display("FAIL flush_no_late_result: got 1 want 0"); end
    drive(1'b1, OP_ADD, 64'd5, 64'd5, 64'h300, 64'd4, 1'b1, 3'b000, 5'd2, 4'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++;
      $display("FAIL flush_branch: got %b/%b want 0/0", bus.redirect_valid, bus.out_valid); end
    tick();
  endtask

  task automatic test_rst_mid();
    logic rose;
    drive(1'b1, OP_ADD, 64'd0, 64'd0, 64'h800, 64'd6, 1'b1, 3'b000, 5'd7, 4'd0);
    tick();
    drive(1'b1, OP_MUL, 64'd3, 64'd5, 64'h804, 64'd0, 1'b0, 3'd0, 5'd7, 4'd0);
    tick();
    idle();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_alu !== 64'd0 || bus.redirect_pc !== 64'd0) begin n_err++;
      $display("FAIL rst_mid_mul: got %b/%b/%h/%h want 0/1/0/0", bus.out_valid, bus.in_ready, bus.out_alu, bus.redirect_pc); end
    rose = 1'b0;
    repeat (70) begin tick(); if (bus.out_valid !== 1'b0) rose = 1'b1; end
    n_cmp++; if (rose !== 1'b0) begin n_err++; $display("FAIL rst_no_late_result: got 1 want 0"); end
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 64'd1, 64'd2, 64'h900, 64'd0, 1'b0, 3'd0, 5'd8, 4'b1111);
    tick();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_alu !== 64'd3) begin n_err++;
      $display("FAIL rst_pre_hold: got %b/%h want 1/3", bus.out_valid, bus.out_alu); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_alu !== 64'd0 || bus.out_regwrite !== 1'b0) begin n_err++;
      $display("FAIL rst_held: got %b/%h/%b want 0/0/0", bus.out_valid, bus.out_alu, bus.out_regwrite); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.out_ready = 1'b1;
    bus_nm.in_valid = 1'b0; bus_nm.alu_ctrl = 4'd0; bus_nm.rd1 = 64'd0; bus_nm.rd2 = 64'd0;
    bus_nm.pc = 64'd0; bus_nm.imm = 64'd0; bus_nm.branch = 1'b0; bus_nm.br_funct3 = 3'd0;
    bus_nm.rd_addr = 5'd0; bus_nm.memwrite_in = 1'b0; bus_nm.memread_in = 1'b0;
    bus_nm.memtoreg_in = 1'b0; bus_nm.regwrite_in = 1'b0; bus_nm.out_ready = 1'b1;
    #1;
    test_reset();
    test_add();
    test_branch();
    test_shifts();
    test_back_to_back();
    drain();
    test_mul();
    test_mul_disabled();
    drain();
    test_backpressure();
    drain();
    test_flush();
    drain();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
